// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder. The optional sub port exists only when
// SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, sub, input busy, done, sum, carry_out);
    modport slave  (input start, a, b, sub, output busy, done, sum, carry_out);
`else
    modport master (output start, a, b, input busy, done, sum, carry_out);
    modport slave  (input start, a, b, output busy, done, sum, carry_out);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add per clock, LSB first, WIDTH-bit sum plus carry-out.
// Define SERIAL_ADDER_SUB_EN to add a sub input that computes a-b instead of a+b.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    serial_adder_if.slave   bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             c;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             done_q;

    logic             h1_s;
    logic             h1_c;
    logic             h2_s;
    logic             h2_c;
    logic             c_next;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // Two cascaded half adders; their carries OR into the next carry.
    assign h1_s   = a_sh[0] ^ b_sh[0];
    assign h1_c   = a_sh[0] & b_sh[0];
    assign h2_s   = h1_s ^ c;
    assign h2_c   = h1_s & c;
    assign c_next = h1_c | h2_c;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
    assign b_load = bus.sub ? ~bus.b : bus.b;
    assign c_load = bus.sub;
`else
    assign b_load = bus.b;
    assign c_load = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= b_load;
                        c     <= c_load;
                        cnt   <= '0;
                        res   <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    c    <= c_next;
                    res  <= {h2_s, res[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    sum_q  <= res;
                    cout_q <= c;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state == ADD) || (state == DONE);
    assign bus.done      = done_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (WIDTH=8) against an arithmetic model.
// Subtract-mode checks run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_adder_if #(.WIDTH(W)) sif ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; returns {carry_out, sum}.
    function automatic logic [8:0] modelResult(input logic [7:0] ma, input logic [7:0] mb,
                                               input logic msub);
        logic [8:0] r;
        if (msub) begin
            r[7:0] = ma - mb;
            r[8]   = (ma >= mb);
        end else begin
            r = {1'b0, ma} + {1'b0, mb};
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic driveOp(input logic [7:0] ta, input logic [7:0] tbv, input logic tsub);
        sif.start = 1'b1;
        sif.a     = ta;
        sif.b     = tbv;
`ifdef SERIAL_ADDER_SUB_EN
        sif.sub   = tsub;
`else
        if (tsub) $display("[TB] note: sub ignored in add-only build");
`endif
    endtask

    // One full operation: latency, held result during ADD, result, done pulse width.
    task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tbv,
                                 input logic tsub, input string tag);
        logic [7:0] prevSum;
        logic       prevC;
        logic [8:0] exp;
        int         lat;
        bit         seen;
        bit         heldOk;
        exp = modelResult(ta, tbv, tsub);
        @(negedge clk);
        prevSum = sif.sum;
        prevC   = sif.carry_out;
        driveOp(ta, tbv, tsub);
        @(negedge clk);
        sif.start = 1'b0;
        sif.a     = 8'($urandom);
        sif.b     = 8'($urandom);
        checkOutput({tag, "_busy"}, 32'(sif.busy), 1);
        lat    = 0;
        seen   = 0;
        heldOk = 1;
        while (!seen && lat <= 20) begin
            if (sif.done) begin
                seen = 1;
            end else begin
                if (sif.sum !== prevSum || sif.carry_out !== prevC) heldOk = 0;
                @(negedge clk);
                lat++;
            end
        end
        checkOutput({tag, "_seen"}, 32'(seen), 1);
        checkOutput({tag, "_lat"}, 32'(lat), 9);
        checkOutput({tag, "_hold"}, 32'(heldOk), 1);
        checkOutput({tag, "_sum"}, 32'(sif.sum), 32'(exp[7:0]));
        checkOutput({tag, "_cout"}, 32'(sif.carry_out), 32'(exp[8]));
        @(negedge clk);
        checkOutput({tag, "_pulse"}, 32'(sif.done), 0);
        checkOutput({tag, "_idle"}, 32'(sif.busy), 0);
        checkOutput({tag, "_keep"}, 32'(sif.sum), 32'(exp[7:0]));
    endtask

    initial begin
        logic [8:0] q[$];
        logic [8:0] e;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;
        int         cyc;
        int         lastCyc;
        int         nDone;
        logic [7:0] doneSum;
        logic       doneC;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        sif.start = 1'b0;
        sif.a     = '0;
        sif.b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sif.sub   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_busy", 32'(sif.busy), 0);
        checkOutput("rst_done", 32'(sif.done), 0);
        checkOutput("rst_sum", 32'(sif.sum), 0);
        checkOutput("rst_cout", 32'(sif.carry_out), 0);

        applyStimulus(8'h00, 8'h00, 1'b0, "zero");
        applyStimulus(8'hFF, 8'h01, 1'b0, "ff_01");
        applyStimulus(8'hA5, 8'h5A, 1'b0, "a5_5a");
        applyStimulus(8'h80, 8'h80, 1'b0, "80_80");

        // start pulsed while busy must be ignored
        @(negedge clk);
        driveOp(8'h12, 8'h34, 1'b0);
        @(negedge clk);
        sif.start = 1'b0;
        repeat (2) @(negedge clk);
        driveOp(8'hFF, 8'hFF, 1'b0);
        @(negedge clk);
        sif.start = 1'b0;
        nDone   = 0;
        doneSum = '0;
        doneC   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sif.done) begin
                nDone++;
                doneSum = sif.sum;
                doneC   = sif.carry_out;
            end
            @(negedge clk);
        end
        checkOutput("busy_ndone", 32'(nDone), 1);
        checkOutput("busy_sum", 32'(doneSum), 32'h46);
        checkOutput("busy_cout", 32'(doneC), 0);
        checkOutput("busy_hold", 32'(sif.sum), 32'h46);

        // reset mid-operation aborts without a done pulse
        driveOp(8'h0F, 8'h01, 1'b0);
        @(negedge clk);
        sif.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 32'(sif.busy), 0);
        checkOutput("abort_sum", 32'(sif.sum), 0);
        checkOutput("abort_cout", 32'(sif.carry_out), 0);
        nDone = 0;
        for (int i = 0; i < 12; i++) begin
            if (sif.done) nDone++;
            @(negedge clk);
        end
        checkOutput("abort_nodone", 32'(nDone), 0);
        applyStimulus(8'h03, 8'h04, 1'b0, "after_abort");

        // rst and start together: rst wins
        @(negedge clk);
        rst = 1'b1;
        driveOp(8'h11, 8'h22, 1'b0);
        @(negedge clk);
        rst       = 1'b0;
        sif.start = 1'b0;
        @(negedge clk);
        checkOutput("rst_start_busy", 32'(sif.busy), 0);

        // back-to-back with start held high
        @(negedge clk);
        ra = 8'($urandom);
        rb = 8'($urandom);
        driveOp(ra, rb, 1'b0);
        q.push_back(modelResult(ra, rb, 1'b0));
        cyc     = 0;
        lastCyc = 0;
        nDone   = 0;
        while (nDone < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (sif.done) begin
                nDone++;
                e = q.pop_front();
                checkOutput("b2b_sum", 32'(sif.sum), 32'(e[7:0]));
                checkOutput("b2b_cout", 32'(sif.carry_out), 32'(e[8]));
                checkOutput("b2b_period", 32'(cyc - lastCyc), 10);
                lastCyc = cyc;
                if (nDone < 8) begin
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    driveOp(ra, rb, 1'b0);
                    q.push_back(modelResult(ra, rb, 1'b0));
                end else begin
                    sif.start = 1'b0;
                end
            end
        end
        checkOutput("b2b_count", 32'(nDone), 8);
        sif.start = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("b2b_quiet", 32'(sif.busy), 0);

`ifdef SERIAL_ADDER_SUB_EN
        applyStimulus(8'h05, 8'h07, 1'b1, "sub_05_07");
        applyStimulus(8'h07, 8'h05, 1'b1, "sub_07_05");
        applyStimulus(8'h07, 8'h05, 1'b0, "add_07_05");
`endif

        for (int i = 0; i < 256; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            applyStimulus(ra, rb, rs, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
